// File: rtl/gfx_pkg.sv
// gfx_pkg: shared raster constants and the pixel arbiter state encoding.
package gfx_pkg;
  localparam int HRES_DEF = 640;
  localparam int VRES_DEF = 480;
  localparam int ADDR_W = 19;
  localparam int COL_W = 4;
  localparam int COORD_W = 11;
  typedef enum logic {ARB, BURST} arb_state_t;
endpackage

// File: rtl/rr_select.sv
// rr_select: combinational round-robin pick of the first valid requester at or above ptr.
module rr_select #(
  parameter int N = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  winner,
  output logic          any
);
  logic found;
  int idx;
  always_comb begin
    winner = '0;
    found = 1'b0;
    idx = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && valid[idx]) begin
        winner[idx] = 1'b1;
        found = 1'b1;
      end
    end
  end
  assign any = |valid;
endmodule

// File: rtl/pixel_arbiter.sv
// pixel_arbiter: round-robin burst arbiter feeding one framebuffer write port with clipping.
// Define PIXEL_ARB_STATS_EN to add the wr_count/clip_count statistics outputs.
module pixel_arbiter
  import gfx_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int BURST_MAX = 16,
  parameter int HRES = HRES_DEF,
  parameter int VRES = VRES_DEF
) (
  input  logic                          clk,
  input  logic                          nReset,
  input  logic [NREQ-1:0]               req_valid,
  input  logic [NREQ-1:0][COORD_W-1:0]  req_x,
  input  logic [NREQ-1:0][COORD_W-1:0]  req_y,
  input  logic [NREQ-1:0][COL_W-1:0]    req_colour,
  output logic [NREQ-1:0]               req_ready,
  output logic                          fb_we,
  output logic [ADDR_W-1:0]             fb_addr,
  output logic [COL_W-1:0]              fb_data,
  input  logic                          fb_ready,
  output logic                          busy
`ifdef PIXEL_ARB_STATS_EN
  ,
  output logic [15:0]                   wr_count,
  output logic [15:0]                   clip_count
`endif
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = $clog2(BURST_MAX + 1);
  arb_state_t state, state_nx;
  logic [PW-1:0] grant, grant_nx, rr_ptr, rr_ptr_nx, win_idx, g_inc;
  logic [BW-1:0] beat, beat_nx;
  logic [NREQ-1:0] winner;
  logic any, gv, xfer, clip;
  logic [COORD_W-1:0] sx, sy;
  logic [ADDR_W-1:0] addr;

  rr_select #(.N(NREQ), .PW(PW)) u_rr (
    .valid  (req_valid),
    .ptr    (rr_ptr),
    .winner (winner),
    .any    (any)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NREQ; i++)
      if (winner[i]) win_idx = PW'(i);
    g_inc = (grant == PW'(NREQ - 1)) ? '0 : grant + PW'(1);
    gv = req_valid[grant];
    sx = req_x[grant];
    sy = req_y[grant];
    // a transfer may only land when the output register is free or draining this cycle
    xfer = (state == BURST) && gv && (!fb_we || fb_ready);
    req_ready = xfer ? (NREQ'(1) << grant) : '0;
    clip = (int'(sx) >= HRES) || (int'(sy) >= VRES);
    addr = ADDR_W'(sy) * ADDR_W'(HRES) + ADDR_W'(sx);
    busy = (state == BURST) || fb_we;
  end

  always_comb begin
    state_nx = state;
    grant_nx = grant;
    rr_ptr_nx = rr_ptr;
    beat_nx = beat;
    if (state == ARB) begin
      if (any) begin
        state_nx = BURST;
        grant_nx = win_idx;
        beat_nx = '0;
      end
    end else begin
      if (xfer) beat_nx = beat + BW'(1);
      if (!gv || (xfer && beat == BW'(BURST_MAX - 1))) begin
        state_nx = ARB;
        rr_ptr_nx = g_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge nReset)
    if (!nReset) begin
      state <= ARB;
      grant <= '0;
      rr_ptr <= '0;
      beat <= '0;
    end else begin
      state <= state_nx;
      grant <= grant_nx;
      rr_ptr <= rr_ptr_nx;
      beat <= beat_nx;
    end

  // clipped pixels leave fb_we low for their slot and keep the old address/data
  always_ff @(posedge clk or negedge nReset)
    if (!nReset) begin
      fb_we <= 1'b0;
      fb_addr <= '0;
      fb_data <= '0;
    end else if (xfer) begin
      fb_we <= !clip;
      if (!clip) begin
        fb_addr <= addr;
        fb_data <= req_colour[grant];
      end
    end else if (fb_ready) begin
      fb_we <= 1'b0;
    end

`ifdef PIXEL_ARB_STATS_EN
  always_ff @(posedge clk or negedge nReset)
    if (!nReset) begin
      wr_count <= '0;
      clip_count <= '0;
    end else begin
      if (fb_we && fb_ready && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      if (xfer && clip && clip_count != 16'hFFFF) clip_count <= clip_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_pixel_arbiter.sv
// tb_pixel_arbiter: directed scoreboard bench for pixel_arbiter (default 4 requesters, 640x480).
module tb_pixel_arbiter;
  localparam int NREQ = 4;
  logic clk = 1'b0;
  logic nReset = 1'b0;
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0][10:0] req_x, req_y;
  logic [NREQ-1:0][3:0] req_colour;
  logic [NREQ-1:0] req_ready;
  logic fb_we, fb_ready, busy;
  logic [18:0] fb_addr;
  logic [3:0] fb_data;
`ifdef PIXEL_ARB_STATS_EN
  logic [15:0] wr_count, clip_count;
`endif

  always #5 clk = ~clk;

  pixel_arbiter dut (
    .clk        (clk),
    .nReset     (nReset),
    .req_valid  (req_valid),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_colour (req_colour),
    .req_ready  (req_ready),
    .fb_we      (fb_we),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .fb_ready   (fb_ready),
    .busy       (busy)
`ifdef PIXEL_ARB_STATS_EN
    ,
    .wr_count   (wr_count),
    .clip_count (clip_count)
`endif
  );

  typedef struct {int x; int y; int c;} pix_t;
  typedef struct {int a; int d;} wr_t;
  typedef struct {int r; int cyc;} gl_t;
  pix_t src_q[NREQ][$];
  wr_t exp_q[$];
  gl_t glog[$];
  int checks = 0, failures = 0, cyc = 0;
  logic [NREQ-1:0] tx;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++)
      if (src_q[i].size() > 0) begin
        req_valid[i] = 1'b1;
        req_x[i] = 11'(src_q[i][0].x);
        req_y[i] = 11'(src_q[i][0].y);
        req_colour[i] = 4'(src_q[i][0].c);
      end else begin
        req_valid[i] = 1'b0;
        req_x[i] = '0;
        req_y[i] = '0;
        req_colour[i] = '0;
      end
  endtask

  task automatic pix(input int r, input int x, input int y, input int c, input bit expect_wr);
    src_q[r].push_back('{x, y, c});
    if (expect_wr) exp_q.push_back('{y * 640 + x, c});
  endtask

  task automatic expw(input int x, input int y, input int c);
    exp_q.push_back('{y * 640 + x, c});
  endtask

  function automatic int pending();
    int n = exp_q.size();
    for (int i = 0; i < NREQ; i++) n += src_q[i].size();
    return n;
  endfunction

  task automatic rst();
    @(negedge clk);
    #2 nReset = 1'b0;
    for (int i = 0; i < NREQ; i++) src_q[i].delete();
    exp_q.delete();
    glog.delete();
    drive();
    #1;
    chk("rst_fb_we", fb_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_fb_addr", fb_addr, 0);
    chk("rst_fb_data", fb_data, 0);
    @(negedge clk);
    #2 nReset = 1'b1;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((pending() != 0 || busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk(name, pending(), 0);
  endtask

  task automatic wait_we();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fb_we && n < 200);
    chk("saw_fb_we", fb_we, 1);
  endtask

  // scoreboard monitor and requester models
  initial begin
    wr_t e;
    tx = '0;
    forever begin
      @(negedge clk);
      if (fb_we && fb_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual_addr=%0d actual_data=%0d required=none", fb_addr, fb_data);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", fb_addr, e.a);
          chk("wr_data", fb_data, e.d);
        end
      end
      tx = req_valid & req_ready;
      @(posedge clk);
      cyc++;
      #1;
      if (nReset)
        for (int i = 0; i < NREQ; i++)
          if (tx[i] && src_q[i].size() > 0) begin
            void'(src_q[i].pop_front());
            glog.push_back('{i, cyc});
          end
      drive();
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    req_valid = '0;
    req_x = '0;
    req_y = '0;
    req_colour = '0;
    fb_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("init_fb_we", fb_we, 0);
    chk("init_busy", busy, 0);

    // single requester, 20 pixels, forced release after 16
    rst();
    for (int k = 0; k < 20; k++) pix(0, k, 2, k & 15, 1'b1);
    wait_done("t1_drain");
    chk("t1_xfers", glog.size(), 20);
    if (glog.size() >= 17) begin
      chk("t1_gap_in_burst", glog[15].cyc - glog[14].cyc, 1);
      chk("t1_gap_release", glog[16].cyc - glog[15].cyc, 2);
    end

    // two contending requesters alternate 16-pixel grants
    rst();
    for (int k = 0; k < 32; k++) begin
      pix(1, k, 20, 1, 1'b0);
      pix(3, k, 30, 3, 1'b0);
    end
    for (int k = 0; k < 16; k++) expw(k, 20, 1);
    for (int k = 0; k < 16; k++) expw(k, 30, 3);
    for (int k = 16; k < 32; k++) expw(k, 20, 1);
    for (int k = 16; k < 32; k++) expw(k, 30, 3);
    wait_done("t2_drain");
    chk("t2_xfers", glog.size(), 64);
    if (glog.size() == 64) begin
      chk("t2_grant0", glog[0].r, 1);
      chk("t2_grant1", glog[16].r, 3);
      chk("t2_grant2", glog[32].r, 1);
      chk("t2_grant3", glog[48].r, 3);
    end

    // framebuffer stall holds the output and blocks transfers
    rst();
    for (int k = 0; k < 6; k++) pix(0, k + 100, 5, 7, 1'b1);
    wait_we();
    @(posedge clk);
    #1 fb_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_we", fb_we, 1);
      chk("stall_addr", fb_addr, exp_q.size() > 0 ? exp_q[0].a : -1);
      chk("stall_ready", req_ready, 0);
    end
    @(posedge clk);
    #1 fb_ready = 1'b1;
    wait_done("t3_drain");

    // off-screen pixel is consumed without a write
    rst();
    pix(1, 640, 10, 5, 1'b0);
    pix(1, 5, 479, 9, 1'b0);
    exp_q.push_back('{306565, 9});
    wait_done("t4_drain");
    chk("t4_xfers", glog.size(), 2);
`ifdef PIXEL_ARB_STATS_EN
    chk("t4_clip_count", clip_count, 1);
    chk("t4_wr_count", wr_count, 1);
`endif

    // requester 2 drops after 3 pixels; pointer moves to 3
    rst();
    for (int k = 0; k < 3; k++) pix(2, k, 7, 2, 1'b1);
    n = 0;
    while (glog.size() < 1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t5_started", glog.size() >= 1, 1);
    for (int k = 0; k < 2; k++) pix(3, k, 8, 3, 1'b1);
    for (int k = 0; k < 2; k++) pix(0, k, 9, 4, 1'b1);
    wait_done("t5_drain");
    chk("t5_xfers", glog.size(), 7);
    if (glog.size() == 7) begin
      chk("t5_after_drop", glog[3].r, 3);
      chk("t5_wrap", glog[5].r, 0);
    end

    // reset during a stalled burst drops the pending write
    rst();
    for (int k = 0; k < 10; k++) pix(1, k, 11, 6, 1'b1);
    wait_we();
    @(posedge clk);
    #1 fb_ready = 1'b0;
    rst();
    fb_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("t6_idle_we", fb_we, 0);
    for (int k = 0; k < 2; k++) pix(0, k, 12, 8, 1'b1);
    for (int k = 0; k < 2; k++) pix(2, k, 13, 10, 1'b1);
    wait_done("t6_drain");
    chk("t6_xfers", glog.size(), 4);
    if (glog.size() > 0) chk("t6_first_grant", glog[0].r, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
